rr_mux_4x1: RTL and testbench

//   Merging counterpart of the 1x4 demux: gathers four independent valid/ready

---
 rtl/rr_mux_4x1.sv | 76 +++++++
 tb/tb_rr_mux_4x1.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4x1.sv
// rr_mux_4x1: merges four valid/ready streams onto one registered output.
// Round-robin grant; out_sel records the source channel of the held beat.
module rr_mux_4x1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    input  logic               out_ready
);

    logic [1:0]       prio_q, prio_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;

    logic       load_en;
    logic       grant;
    logic [1:0] g;
    logic [1:0] idx;

    assign load_en = ~valid_q | out_ready;

    // Search downwards so the lowest offset from prio wins.
    always_comb begin
        g   = prio_q;
        idx = prio_q;
        for (int i = 3; i >= 0; i--) begin
            idx = prio_q + 2'(i);
            if (in_valid[idx]) g = idx;
        end
    end

    // rst_n gating keeps in_ready low during reset.
    assign grant    = (|in_valid) & load_en & rst_n;
    assign in_ready = grant ? (4'b0001 << g) : 4'b0000;

    always_comb begin
        prio_d  = prio_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (grant) begin
            data_d  = in_data[int'(g)*WIDTH +: WIDTH];
            sel_d   = g;
            valid_d = 1'b1;
            prio_d  = g + 2'd1;
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            prio_q  <= prio_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// tb_rr_mux_4x1: directed scenario tasks for the 4:1 round-robin mux.
// Inputs change on negedge; outputs are sampled 1ns after edges.
module tb_rr_mux_4x1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int vecs;
    int errs;

    rr_mux_4x1 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        in_data   = 32'h13121110;
        #2;
        vecs++;
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_valid got %b want 0", out_valid); errs++;
        end
        vecs++;
        if (out_data !== 8'h00) begin
            $display("FAIL rst_data got %h want 00", out_data); errs++;
        end
        vecs++;
        if (out_sel !== 2'd0) begin
            $display("FAIL rst_sel got %0d want 0", out_sel); errs++;
        end
        vecs++;
        if (in_ready !== 4'b0000) begin
            $display("FAIL rst_ready got %b want 0000", in_ready); errs++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0001) begin
            $display("FAIL rst_first_grant got %b want 0001", in_ready); errs++;
        end
        @(posedge clk); #1;
        vecs++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h10) begin
            $display("FAIL rst_first_beat got v=%b s=%0d d=%h want v=1 s=0 d=10",
                     out_valid, out_sel, out_data);
            errs++;
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid  = 4'b0100;
        in_data   = 32'h00A50000;
        out_ready = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0100) begin
            $display("FAIL single_ready got %b want 0100", in_ready); errs++;
        end
        @(posedge clk); #1;
        vecs++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
            $display("FAIL single_beat got v=%b d=%h s=%0d want v=1 d=a5 s=2",
                     out_valid, out_data, out_sel);
            errs++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [6];
        logic [7:0] exp_dat [6];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        do_reset();
        in_valid  = 4'hF;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            vecs++;
            if (in_ready !== (4'b0001 << exp_sel[i])) begin
                $display("FAIL rr_ready[%0d] got %b want %b", i, in_ready,
                         4'b0001 << exp_sel[i]);
                errs++;
            end
            @(posedge clk); #1;
            vecs++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[i] ||
                out_data !== exp_dat[i]) begin
                $display("FAIL rr_beat[%0d] got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         i, out_valid, out_sel, out_data, exp_sel[i], exp_dat[i]);
                errs++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid  = 4'b0010;
        in_data   = 32'h13123C10;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if (out_data !== 8'h3C || out_sel !== 2'd1) begin
            $display("FAIL bp_load got d=%h s=%0d want d=3c s=1", out_data, out_sel);
            errs++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            vecs++;
            if (in_ready !== 4'b0000) begin
                $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready); errs++;
            end
            @(posedge clk); #1;
            vecs++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1) begin
                $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want v=1 d=3c s=1",
                         i, out_valid, out_data, out_sel);
                errs++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0100) begin
            $display("FAIL bp_release_ready got %b want 0100", in_ready); errs++;
        end
        @(posedge clk); #1;
        vecs++;
        if (out_sel !== 2'd2 || out_data !== 8'h12) begin
            $display("FAIL bp_release_beat got s=%0d d=%h want s=2 d=12",
                     out_sel, out_data);
            errs++;
        end
    endtask

    task automatic test_idle_gap();
        do_reset();
        in_valid  = 4'b0100;
        in_data   = 32'h00220000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (in_ready !== 4'b0000) begin
                $display("FAIL gap_ready[%0d] got %b want 0000", i, in_ready); errs++;
            end
            @(posedge clk); #1;
            vecs++;
            if (out_valid !== 1'b0 || out_sel !== 2'd2 || out_data !== 8'h22) begin
                $display("FAIL gap_out[%0d] got v=%b s=%0d d=%h want v=0 s=2 d=22",
                         i, out_valid, out_sel, out_data);
                errs++;
            end
            @(negedge clk);
        end
        in_valid = 4'b1001;
        in_data  = 32'h33000030;
        #1;
        vecs++;
        if (in_ready !== 4'b1000) begin
            $display("FAIL gap_grant3 got %b want 1000", in_ready); errs++;
        end
        @(posedge clk); #1;
        vecs++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 8'h33) begin
            $display("FAIL gap_beat3 got v=%b s=%0d d=%h want v=1 s=3 d=33",
                     out_valid, out_sel, out_data);
            errs++;
        end
        vecs++;
        if (in_ready !== 4'b0001) begin
            $display("FAIL gap_grant0 got %b want 0001", in_ready); errs++;
        end
        @(posedge clk); #1;
        vecs++;
        if (out_sel !== 2'd0 || out_data !== 8'h30) begin
            $display("FAIL gap_beat0 got s=%0d d=%h want s=0 d=30", out_sel, out_data);
            errs++;
        end
    endtask

    task automatic test_midreset();
        do_reset();
        in_valid  = 4'b0001;
        in_data   = 32'h00000055;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            $display("FAIL mid_async got v=%b d=%h s=%0d want v=0 d=00 s=0",
                     out_valid, out_data, out_sel);
            errs++;
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b0011;
        in_data   = 32'h00007766;
        out_ready = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 4'b0001) begin
            $display("FAIL mid_grant got %b want 0001", in_ready); errs++;
        end
        @(posedge clk); #1;
        vecs++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h66) begin
            $display("FAIL mid_beat got v=%b s=%0d d=%h want v=1 s=0 d=66",
                     out_valid, out_sel, out_data);
            errs++;
        end
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        rst_n     = 1'b0;
        in_valid  = 4'h0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_idle_gap();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
